// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: memsize codes,
// response kinds and the data-access alignment rule.
package mem_pkg;

  localparam logic [2:0] MS_B  = 3'b000;
  localparam logic [2:0] MS_H  = 3'b001;
  localparam logic [2:0] MS_W  = 3'b010;
  localparam logic [2:0] MS_BU = 3'b100;
  localparam logic [2:0] MS_HU = 3'b101;

  typedef enum logic [2:0] {
    R_NONE,
    R_FETCH,
    R_LOAD,
    R_STORE,
    R_ERR
  } resp_e;

  // Halves must sit on an even byte, words on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      MS_H, MS_HU: return addr[0];
      MS_W:        return addr != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been refused.
module starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // Count refused cycles; clear wins over increment, stop at STARVE_MAX.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != CW'(STARVE_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store. Data has
// priority unless fetch has been starved for STARVE_MAX cycles; every grant
// produces a registered response one cycle later.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          m_en,
  output logic          m_we,
  output logic [2:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  logic  fetch_win;
  logic  data_win;
  logic  misal;
  logic  starve_sat;
  resp_e resp;
  resp_e resp_next;

  // Arbitration and memory-port mux; the bus is all zeros when not accessing.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;

    fetch_win = !reset && i_req && (!d_req || starve_sat);
    data_win  = !reset && d_req && !fetch_win;
    misal     = data_win && is_misaligned(d_size, d_addr[1:0]);

    if (fetch_win) begin
      m_en   = 1'b1;
      m_size = MS_W;
      m_addr = i_addr;
    end else if (data_win && !misal) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  assign i_gnt = fetch_win;
  assign d_gnt = data_win;

  starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (i_req && !fetch_win),
    .clr  (fetch_win || !i_req),
    .sat  (starve_sat)
  );

  // Response register: remembers what kind of access was granted last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp <= R_NONE;
    end else begin
      resp <= resp_next;
    end
  end

  // Next response kind from this cycle's grant; outputs decoded from resp.
  always_comb begin
    resp_next = R_NONE;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;

    if (fetch_win) begin
      resp_next = R_FETCH;
    end else if (data_win) begin
      if (misal)     resp_next = R_ERR;
      else if (d_we) resp_next = R_STORE;
      else           resp_next = R_LOAD;
    end

    // An in-flight response is dropped while reset is held.
    if (!reset) begin
      case (resp)
        R_FETCH: begin
          i_rvalid = 1'b1;
          i_rdata  = m_rdata;
        end
        R_LOAD: begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
        end
        R_STORE: d_rvalid = 1'b1;
        R_ERR: begin
          d_rvalid = 1'b1;
          d_err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a negedge monitor predicts grants and
// queues the expected response for the following cycle; scenario tasks add
// targeted inline checks.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int AW         = 32;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [2:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          m_en;
  logic          m_we;
  logic [2:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        iv;
    logic [31:0] idata;
    logic        dv;
    logic [31:0] ddata;
    logic        derr;
  } exp_t;

  exp_t exp_q[$];
  int   m_starve = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .AW        (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_size  (m_size),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wkey(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(wkey(a)) ? ref_mem[wkey(a)] : 32'h0;
  endfunction

  function automatic logic tb_misal(input logic [2:0] s, input logic [1:0] a);
    if (s == 3'b001 || s == 3'b101) return a[0];
    if (s == 3'b010) return a != 2'b00;
    return 1'b0;
  endfunction

  // Memory behind the arbiter: reads return data the cycle after m_en.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) env_mem[wkey(m_addr)] = m_wdata;
      m_rdata <= env_mem.exists(wkey(m_addr)) ? env_mem[wkey(m_addr)] : 32'h0;
    end
  end

  // Monitor: check last cycle's queued response, predict this cycle's grant.
  always @(negedge clk) begin
    exp_t e;
    exp_t nx;
    logic ef, ed, em, men;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{iv: 1'b0, idata: 32'h0, dv: 1'b0, ddata: 32'h0, derr: 1'b0};
    if (reset) e = '{iv: 1'b0, idata: 32'h0, dv: 1'b0, ddata: 32'h0, derr: 1'b0};

    n_cmp++; if (i_rvalid !== e.iv) begin n_bad++; $display("FAIL sb_i_rvalid @%0t: got %b want %b", $time, i_rvalid, e.iv); end
    n_cmp++; if (i_rdata !== e.idata) begin n_bad++; $display("FAIL sb_i_rdata @%0t: got %h want %h", $time, i_rdata, e.idata); end
    n_cmp++; if (d_rvalid !== e.dv) begin n_bad++; $display("FAIL sb_d_rvalid @%0t: got %b want %b", $time, d_rvalid, e.dv); end
    n_cmp++; if (d_rdata !== e.ddata) begin n_bad++; $display("FAIL sb_d_rdata @%0t: got %h want %h", $time, d_rdata, e.ddata); end
    n_cmp++; if (d_err !== e.derr) begin n_bad++; $display("FAIL sb_d_err @%0t: got %b want %b", $time, d_err, e.derr); end

    ef  = !reset && i_req && (!d_req || m_starve == STARVE_MAX);
    ed  = !reset && d_req && !ef;
    em  = ed && tb_misal(d_size, d_addr[1:0]);
    men = ef || (ed && !em);

    n_cmp++; if (i_gnt !== ef) begin n_bad++; $display("FAIL mon_i_gnt @%0t: got %b want %b", $time, i_gnt, ef); end
    n_cmp++; if (d_gnt !== ed) begin n_bad++; $display("FAIL mon_d_gnt @%0t: got %b want %b", $time, d_gnt, ed); end
    n_cmp++; if (m_en !== men) begin n_bad++; $display("FAIL mon_m_en @%0t: got %b want %b", $time, m_en, men); end
    n_cmp++; if (int'(dut.u_starve.cnt) !== m_starve) begin n_bad++; $display("FAIL mon_starve @%0t: got %0d want %0d", $time, dut.u_starve.cnt, m_starve); end

    nx = '{iv: 1'b0, idata: 32'h0, dv: 1'b0, ddata: 32'h0, derr: 1'b0};
    if (ef) begin
      nx.iv    = 1'b1;
      nx.idata = ref_rd(i_addr);
    end else if (ed) begin
      nx.dv = 1'b1;
      if (em) nx.derr = 1'b1;
      else if (d_we) ref_mem[wkey(d_addr)] = d_wdata;
      else nx.ddata = ref_rd(d_addr);
    end
    exp_q.push_back(nx);

    if (reset || ef || !i_req) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_size = 3'b010; d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b%b want 00", i_gnt, d_gnt); end
    n_cmp++; if (m_en !== 1'b0 || m_we !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || m_size !== 3'b000) begin n_bad++; $display("FAIL rst_mbus: got en=%b we=%b addr=%h", m_en, m_we, m_addr); end
    n_cmp++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got %b%b%b want 000", i_rvalid, d_rvalid, d_err); end
    tick();
    idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    n_cmp++; if (i_gnt !== 1'b1) begin n_bad++; $display("FAIL fetch_gnt: got %b want 1", i_gnt); end
    n_cmp++; if (m_addr !== 32'h10 || m_size !== 3'b010 || m_we !== 1'b0) begin n_bad++; $display("FAIL fetch_mbus: got addr=%h size=%b we=%b", m_addr, m_size, m_we); end
    tick();
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093) begin n_bad++; $display("FAIL fetch_resp: got v=%b %h want 1 00500093", i_rvalid, i_rdata); end
    n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_d_rvalid: got %b want 0", d_rvalid); end
    tick();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_size = 3'b010; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_grant: got gnt=%b we=%b wdata=%h", d_gnt, m_we, m_wdata); end
    tick();
    d_we = 1'b0; d_wdata = 32'h0;
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL st_resp: got v=%b %h want 1 0", d_rvalid, d_rdata); end
    n_cmp++; if (d_gnt !== 1'b1 || m_we !== 1'b0) begin n_bad++; $display("FAIL ld_grant: got gnt=%b we=%b want 1 0", d_gnt, m_we); end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || d_err !== 1'b0) begin n_bad++; $display("FAIL ld_resp: got v=%b %h err=%b", d_rvalid, d_rdata, d_err); end
    tick();
  endtask

  task automatic test_contention();
    int max_cnt = 0;
    int first_i = -1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      logic want_i;
      @(negedge clk);
      want_i = (k % 5 == 4);
      n_cmp++; if (i_gnt !== want_i || d_gnt !== !want_i) begin n_bad++; $display("FAIL cont_pattern[%0d]: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, want_i); end
      n_cmp++; if (int'(dut.u_starve.cnt) !== k % 5) begin n_bad++; $display("FAIL cont_cnt[%0d]: got %0d want %0d", k, dut.u_starve.cnt, k % 5); end
      if (int'(dut.u_starve.cnt) > max_cnt) max_cnt = int'(dut.u_starve.cnt);
      if (i_gnt === 1'b1 && first_i < 0) first_i = k;
      tick();
    end
    n_cmp++; if (max_cnt > STARVE_MAX) begin n_bad++; $display("FAIL sat_max: got %0d want <= %0d", max_cnt, STARVE_MAX); end
    n_cmp++; if (first_i < 0 || first_i > 4) begin n_bad++; $display("FAIL sat_first_fetch: got cycle %0d want 0..4", first_i); end
    idle();
    tick();
  endtask

  task automatic test_misaligned();
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h102;
    @(negedge clk);
    n_cmp++; if (d_gnt !== 1'b1 || m_en !== 1'b0 || m_addr !== '0) begin n_bad++; $display("FAIL mis_w_grant: got gnt=%b en=%b addr=%h", d_gnt, m_en, m_addr); end
    tick();
    d_size = 3'b001; d_addr = 32'h103;
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_w_resp: got v=%b err=%b %h", d_rvalid, d_err, d_rdata); end
    n_cmp++; if (d_gnt !== 1'b1 || m_en !== 1'b0) begin n_bad++; $display("FAIL mis_h_grant: got gnt=%b en=%b want 1 0", d_gnt, m_en); end
    tick();
    d_addr = 32'h102;
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_h_resp: got v=%b err=%b %h", d_rvalid, d_err, d_rdata); end
    n_cmp++; if (m_en !== 1'b1 || m_addr !== 32'h102 || m_size !== 3'b001) begin n_bad++; $display("FAIL ok_h_grant: got en=%b addr=%h size=%b", m_en, m_addr, m_size); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ok_h_resp: got v=%b err=%b %h", d_rvalid, d_err, d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h100;
    @(negedge clk);
    n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_grant: got %b want 1", d_gnt); end
    tick();
    reset = 1'b1; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    n_cmp++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || i_gnt !== 1'b0 || m_en !== 1'b0) begin n_bad++; $display("FAIL rm_drop: got v=%b %h ig=%b en=%b", d_rvalid, d_rdata, i_gnt, m_en); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (int'(dut.u_starve.cnt) !== 0) begin n_bad++; $display("FAIL rm_cnt: got %0d want 0", dut.u_starve.cnt); end
    n_cmp++; if (i_gnt !== 1'b1 || i_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_first_gnt: got g=%b v=%b want 1 0", i_gnt, i_rvalid); end
    tick();
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00500093) begin n_bad++; $display("FAIL rm_first_resp: got v=%b %h", i_rvalid, i_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
      end else begin
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_size = 3'b010;
        d_addr = 32'h200 + 32'(4 * k); d_wdata = 32'hA000_0000 + 32'(k);
      end
      @(negedge clk);
      n_cmp++; if (i_gnt !== (k % 2 == 0) || d_gnt !== (k % 2 == 1)) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got i=%b d=%b", k, i_gnt, d_gnt); end
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200 + 32'(4 * (2 * k + 1));
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    i_addr = '0; d_addr = '0;
    m_rdata = 32'h0;
    idle();
    env_mem[32'h10] = 32'h00500093;
    ref_mem[32'h10] = 32'h00500093;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
